mul_reservation_station: RTL

// - Reservation station in front of the multiplier functional unit.
// - Accepts dispatched ops from the instruction queue and snoops the CDB for missing operands.
// - Issues ops with both operands ready to the multiplier over a valid/ready pair: tag plus flattened {V1,V0}.
// - Allocates the entry tag that rename/regfile use to wait on this op's CDB result.

---
 rtl/mul_rsv_pkg.sv | 23 ++
 rtl/rsv_entry.sv | 58 +++++
 rtl/mul_reservation_station.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mul_rsv_pkg.sv
// Types and helpers shared by the multiplier and add/sub reservation stations.
package mul_rsv_pkg;

  localparam int unsigned RSV_BW_DATA = 32;
  localparam int unsigned RSV_BW_TAG  = 3;

  typedef logic [RSV_BW_TAG-1:0]  tag_t;
  typedef logic [RSV_BW_DATA-1:0] data_t;

  localparam tag_t TAG_NONE = '0;

  typedef struct packed {
    logic            valid;
    tag_t  [1:0]     q;
    data_t [1:0]     v;
  } rsv_entry_t;

  // Tag 0 means "operand already valid", so it can never match a broadcast.
  function automatic logic cdb_hit(input logic cdb_valid, input tag_t cdb_tag, input tag_t q);
    return cdb_valid && (q != TAG_NONE) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/rsv_entry.sv
// One reservation-station slot: operand tags/values, CDB snoop and dispatch-time bypass.
module rsv_entry
  import mul_rsv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic                       i_free,
  input  logic [2*RSV_BW_TAG-1:0]    i_disp_Q_flatten,
  input  logic [2*RSV_BW_DATA-1:0]   i_disp_V_flatten,
  input  logic                       i_cdb_valid,
  input  logic [RSV_BW_TAG-1:0]      i_cdb_tag,
  input  logic [RSV_BW_DATA-1:0]     i_cdb_wdata,
  output logic                       o_valid,
  output logic                       o_rdy,
  output logic [2*RSV_BW_DATA-1:0]   o_V_flatten
);

  rsv_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (i_load) begin
      entry_d.valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        entry_d.q[k] = i_disp_Q_flatten[k*RSV_BW_TAG +: RSV_BW_TAG];
        entry_d.v[k] = i_disp_V_flatten[k*RSV_BW_DATA +: RSV_BW_DATA];
        // Producer broadcasting in the dispatch cycle would otherwise be missed.
        if (cdb_hit(i_cdb_valid, i_cdb_tag, entry_d.q[k])) begin
          entry_d.q[k] = TAG_NONE;
          entry_d.v[k] = i_cdb_wdata;
        end
      end
    end else if (i_free) begin
      entry_d.valid = 1'b0;
    end else if (entry_q.valid) begin
      for (int k = 0; k < 2; k++) begin
        if (cdb_hit(i_cdb_valid, i_cdb_tag, entry_q.q[k])) begin
          entry_d.q[k] = TAG_NONE;
          entry_d.v[k] = i_cdb_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_valid     = entry_q.valid;
  assign o_rdy       = entry_q.valid && (entry_q.q[0] == TAG_NONE) && (entry_q.q[1] == TAG_NONE);
  assign o_V_flatten = entry_q.v;

endmodule

// File: rtl/mul_reservation_station.sv
// Multiplier reservation station: allocates entries on dispatch, snoops the CDB and issues
// the lowest-index ready entry through a one-deep output register.
module mul_reservation_station
  import mul_rsv_pkg::*;
#(
  parameter int unsigned BW_PROCESSOR_DATA = RSV_BW_DATA,
  parameter int unsigned BW_TAG            = RSV_BW_TAG,
  parameter int unsigned N_ENTRY           = 3,
  parameter int unsigned TAG_BASE          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_disp_valid,
  output logic                           o_disp_ready,
  input  logic [2*BW_TAG-1:0]            i_disp_Q_flatten,
  input  logic [2*BW_PROCESSOR_DATA-1:0] i_disp_V_flatten,
  output logic [BW_TAG-1:0]              o_disp_tag,
  input  logic                           i_cdb_valid,
  input  logic [BW_TAG-1:0]              i_cdb_tag,
  input  logic [BW_PROCESSOR_DATA-1:0]   i_cdb_wdata,
  output logic                           o_issue_valid,
  input  logic                           i_issue_ready,
  output logic [BW_TAG-1:0]              o_issue_tag,
  output logic [2*BW_PROCESSOR_DATA-1:0] o_issue_V_flatten
);

  logic [N_ENTRY-1:0]             ent_valid;
  logic [N_ENTRY-1:0]             ent_rdy;
  logic [N_ENTRY-1:0]             ent_load;
  logic [N_ENTRY-1:0]             ent_free;
  logic [2*BW_PROCESSOR_DATA-1:0] ent_v [N_ENTRY];

  logic                           free_found;
  logic [N_ENTRY-1:0]             free_oh;
  logic [BW_TAG-1:0]              free_tag;

  logic                           rdy_found;
  logic [N_ENTRY-1:0]             rdy_oh;
  logic [BW_TAG-1:0]              rdy_tag;
  logic [2*BW_PROCESSOR_DATA-1:0] rdy_v;

  logic                           disp_fire;
  logic                           issue_load;

  logic                           issue_valid_q, issue_valid_d;
  logic [BW_TAG-1:0]              issue_tag_q, issue_tag_d;
  logic [2*BW_PROCESSOR_DATA-1:0] issue_v_q, issue_v_d;

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_entry
    rsv_entry u_entry (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_load           (ent_load[g]),
      .i_free           (ent_free[g]),
      .i_disp_Q_flatten (i_disp_Q_flatten),
      .i_disp_V_flatten (i_disp_V_flatten),
      .i_cdb_valid      (i_cdb_valid),
      .i_cdb_tag        (i_cdb_tag),
      .i_cdb_wdata      (i_cdb_wdata),
      .o_valid          (ent_valid[g]),
      .o_rdy            (ent_rdy[g]),
      .o_V_flatten      (ent_v[g])
    );
  end

  // Lowest-index free entry; derived from entry registers only.
  always_comb begin
    free_found = 1'b0;
    free_oh    = '0;
    free_tag   = BW_TAG'(TAG_BASE);
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
        free_tag   = BW_TAG'(TAG_BASE + i);
      end
    end
  end

  // Lowest-index entry with both operands ready (index order, not age).
  always_comb begin
    rdy_found = 1'b0;
    rdy_oh    = '0;
    rdy_tag   = '0;
    rdy_v     = '0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      if (ent_rdy[i] && !rdy_found) begin
        rdy_found = 1'b1;
        rdy_oh[i] = 1'b1;
        rdy_tag   = BW_TAG'(TAG_BASE + i);
        rdy_v     = ent_v[i];
      end
    end
  end

  assign disp_fire  = i_disp_valid && free_found;
  assign issue_load = (!issue_valid_q || i_issue_ready) && rdy_found;
  assign ent_load   = {N_ENTRY{disp_fire}} & free_oh;
  assign ent_free   = {N_ENTRY{issue_load}} & rdy_oh;

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_tag_d   = issue_tag_q;
    issue_v_d     = issue_v_q;
    if (issue_load) begin
      issue_valid_d = 1'b1;
      issue_tag_d   = rdy_tag;
      issue_v_d     = rdy_v;
    end else if (i_issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_tag_q   <= '0;
      issue_v_q     <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_tag_q   <= issue_tag_d;
      issue_v_q     <= issue_v_d;
    end
  end

  assign o_disp_ready      = free_found;
  assign o_disp_tag        = free_tag;
  assign o_issue_valid     = issue_valid_q;
  assign o_issue_tag       = issue_tag_q;
  assign o_issue_V_flatten = issue_v_q;

endmodule
